// File: rtl/flex_updown_counter_pkg.sv
// Shared types and helpers for the flex up/down counter.
package flex_counter_pkg;

  // Count direction as seen on count_down.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Behaviour at the terminal value as seen on one_shot.
  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_t;

  // Widest count supported by the terminal helper below.
  localparam int MAX_CNT_BITS = 32;

  // Terminal value: the top of the range going up, 1 going down.
  function automatic logic [MAX_CNT_BITS-1:0] terminal_val(
    input dir_t                    dir,
    input logic [MAX_CNT_BITS-1:0] r
  );
    return (dir == DIR_DOWN) ? MAX_CNT_BITS'(1) : r;
  endfunction

endpackage

// File: rtl/flex_updown_counter_if.sv
// Control and status bundle of the flex up/down counter.
interface flex_updown_counter_if #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int NUM_WRAP_BITS = 4
);
  logic                     clear;
  logic                     load;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic                     count_enable;
  logic                     count_down;
  logic                     one_shot;
  logic [NUM_CNT_BITS-1:0]  rollover_val;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     rollover_flag;
  logic                     rollover_pulse;
  logic                     done;
  logic [NUM_WRAP_BITS-1:0] wrap_count;

  // Side that controls the counter.
  modport master (
    output clear, load, load_val, count_enable, count_down, one_shot, rollover_val,
    input  count_out, rollover_flag, rollover_pulse, done, wrap_count
  );

  // The counter itself.
  modport slave (
    input  clear, load, load_val, count_enable, count_down, one_shot, rollover_val,
    output count_out, rollover_flag, rollover_pulse, done, wrap_count
  );
endinterface

// File: rtl/flex_updown_counter_sat_counter.sv
// Saturating event tally with synchronous clear.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  // Tally register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/flex_updown_counter.sv
// Programmable up/down counter with load, wrap/one-shot modes,
// one-cycle rollover pulse and saturating wrap tally.
module flex_updown_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS  = 4,
  parameter int NUM_WRAP_BITS = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  flex_updown_counter_if.slave  bus
);
  typedef logic [NUM_CNT_BITS-1:0] cnt_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);

  cnt_t  count_reg;
  cnt_t  count_next;
  cnt_t  rval;
  cnt_t  term;
  cnt_t  load_clip;
  logic  flag_reg;
  logic  flag_next;
  logic  pulse_reg;
  logic  pulse_next;
  logic  done_reg;
  logic  done_next;
  logic  wrap_event;
  dir_t  dir;
  mode_t mode;
  logic [NUM_WRAP_BITS-1:0] wrap_count;

  assign dir       = bus.count_down ? DIR_DOWN : DIR_UP;
  assign mode      = bus.one_shot ? MODE_ONESHOT : MODE_WRAP;
  assign rval      = bus.rollover_val;
  assign term      = cnt_t'(terminal_val(dir, MAX_CNT_BITS'(rval)));
  // A load never lands outside the valid range.
  assign load_clip = (bus.load_val > rval) ? rval : bus.load_val;

  // Next-state decode: clear > load > enable > hold.
  always_comb begin
    count_next = count_reg;
    done_next  = done_reg;
    wrap_event = 1'b0;
    if (bus.clear) begin
      count_next = '0;
      done_next  = 1'b0;
    end else if (bus.load) begin
      count_next = load_clip;
      done_next  = 1'b0;
    end else if (bus.count_enable) begin
      if (rval == '0) begin
        // Empty range: park at zero, never wrap or finish.
        count_next = '0;
      end else if (dir == DIR_UP) begin
        if (count_reg < rval) begin
          count_next = count_reg + CNT_ONE;
        end else if (count_reg > rval) begin
          // Range shrank under us: restart without counting a wrap.
          count_next = CNT_ONE;
        end else if (mode == MODE_ONESHOT) begin
          done_next = 1'b1;
        end else begin
          count_next = CNT_ONE;
          wrap_event = 1'b1;
        end
      end else begin
        if (count_reg > rval) begin
          count_next = rval;
        end else if (count_reg > CNT_ONE) begin
          count_next = count_reg - CNT_ONE;
        end else if (count_reg == CNT_ONE) begin
          if (mode == MODE_ONESHOT) begin
            done_next = 1'b1;
          end else begin
            count_next = rval;
            wrap_event = 1'b1;
          end
        end else begin
          // Zero is below the range: jump to the top, no wrap.
          count_next = rval;
        end
      end
    end
    pulse_next = wrap_event;
    // Flag tracks the terminal for this cycle's direction; an empty range keeps it low.
    flag_next  = (rval != '0) && !bus.clear && (count_next == term);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_reg <= '0;
      flag_reg  <= 1'b0;
      pulse_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      flag_reg  <= flag_next;
      pulse_reg <= pulse_next;
      done_reg  <= done_next;
    end
  end

  sat_counter #(
    .WIDTH (NUM_WRAP_BITS)
  ) u_wrap_tally (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (bus.clear),
    .inc   (wrap_event),
    .count (wrap_count)
  );

  assign bus.count_out      = count_reg;
  assign bus.rollover_flag  = flag_reg;
  assign bus.rollover_pulse = pulse_reg;
  assign bus.done           = done_reg;
  assign bus.wrap_count     = wrap_count;
endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed vector bench for flex_updown_counter (N=4, 2-bit wrap tally).
module tb_flex_updown_counter;
  localparam int N = 4;
  localparam int W = 2;

  logic clk;
  logic n_rst;

  flex_updown_counter_if #(.NUM_CNT_BITS(N), .NUM_WRAP_BITS(W)) bus ();

  flex_updown_counter #(
    .NUM_CNT_BITS  (N),
    .NUM_WRAP_BITS (W)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         clr;
    logic         ld;
    logic [N-1:0] lv;
    logic         en;
    logic         dn;
    logic         os;
    logic [N-1:0] rv;
    logic         glitch;
    logic [N-1:0] e_cnt;
    logic         e_flag;
    logic         e_pulse;
    logic         e_done;
    logic [W-1:0] e_wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic v(input int rst_n, input int clr, input int ld, input int lv,
                   input int en, input int dn, input int os, input int rv,
                   input int gl, input int cnt, input int flag, input int pulse,
                   input int dne, input int wrap);
    vec_t t;
    t.rst_n  = rst_n[0];
    t.clr    = clr[0];
    t.ld     = ld[0];
    t.lv     = lv[N-1:0];
    t.en     = en[0];
    t.dn     = dn[0];
    t.os     = os[0];
    t.rv     = rv[N-1:0];
    t.glitch = gl[0];
    t.e_cnt  = cnt[N-1:0];
    t.e_flag = flag[0];
    t.e_pulse= pulse[0];
    t.e_done = dne[0];
    t.e_wrap = wrap[W-1:0];
    vecs.push_back(t);
  endtask

  task automatic check(input int idx, input string name, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %0d, want %0d", idx, name, act, exp);
    end
  endtask

  initial begin
    n_rst            = 1'b0;
    bus.clear        = 1'b0;
    bus.load         = 1'b0;
    bus.load_val     = '0;
    bus.count_enable = 1'b0;
    bus.count_down   = 1'b0;
    bus.one_shot     = 1'b0;
    bus.rollover_val = 4'd5;

    //   rst clr ld lv en dn os rv gl | cnt flg pls dne wrp
    // Reset
    v(0,0,0,0, 0,0,0,5,0,  0,0,0,0,0);
    v(0,0,0,0, 0,0,0,5,0,  0,0,0,0,0);
    // Up count, wrap mode, R=5
    v(1,0,0,0, 1,0,0,5,0,  1,0,0,0,0);
    v(1,0,0,0, 1,0,0,5,0,  2,0,0,0,0);
    v(1,0,0,0, 1,0,0,5,0,  3,0,0,0,0);
    v(1,0,0,0, 1,0,0,5,0,  4,0,0,0,0);
    v(1,0,0,0, 1,0,0,5,0,  5,1,0,0,0);
    v(1,0,0,0, 1,0,0,5,0,  1,0,1,0,1);
    v(1,0,0,0, 1,0,0,5,0,  2,0,0,0,1);
    v(1,0,0,0, 1,0,0,5,0,  3,0,0,0,1);
    v(1,0,0,0, 1,0,0,5,0,  4,0,0,0,1);
    v(1,0,0,0, 1,0,0,5,0,  5,1,0,0,1);
    v(1,0,0,0, 1,0,0,5,0,  1,0,1,0,2);
    v(1,0,0,0, 1,0,0,5,0,  2,0,0,0,2);
    v(1,0,0,0, 0,0,0,5,0,  2,0,0,0,2);
    // Down one-shot from 9
    v(1,1,0,0, 0,1,1,9,0,  0,0,0,0,0);
    v(1,0,1,9, 0,1,1,9,0,  9,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  8,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  7,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  6,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  5,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  4,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  3,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  2,0,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  1,1,0,0,0);
    v(1,0,0,0, 1,1,1,9,0,  1,1,0,1,0);
    v(1,0,0,0, 1,1,1,9,0,  1,1,0,1,0);
    v(1,0,0,0, 1,1,1,9,0,  1,1,0,1,0);
    v(1,0,0,0, 1,1,1,9,0,  1,1,0,1,0);
    // Priority: load clears done; clear beats load+enable; load beats enable
    v(1,0,1,4, 0,0,0,5,0,  4,0,0,0,0);
    v(1,1,1,3, 1,0,0,5,0,  0,0,0,0,0);
    v(1,0,1,3, 1,0,0,5,0,  3,0,0,0,0);
    // Range edges
    v(1,0,1,12,0,0,0,7,0,  7,1,0,0,0);
    v(1,0,1,6, 0,0,0,7,0,  6,0,0,0,0);
    v(1,0,0,0, 1,0,0,4,0,  1,0,0,0,0);
    v(1,1,0,0, 0,0,0,7,0,  0,0,0,0,0);
    v(1,0,0,0, 1,1,0,7,0,  7,0,0,0,0);
    v(1,0,0,0, 1,0,0,0,0,  0,0,0,0,0);
    v(1,0,0,0, 0,0,0,0,0,  0,0,0,0,0);
    v(1,0,1,5, 0,0,0,0,0,  0,0,0,0,0);
    // Down wrap event at 1 -> R
    v(1,0,1,2, 0,1,0,3,0,  2,0,0,0,0);
    v(1,0,0,0, 1,1,0,3,0,  1,1,0,0,0);
    v(1,0,0,0, 1,1,0,3,0,  3,0,1,0,1);
    // Saturation, R=2, ten wraps
    v(1,1,0,0, 0,0,0,2,0,  0,0,0,0,0);
    v(1,0,0,0, 1,0,0,2,0,  1,0,0,0,0);
    for (int i = 1; i <= 10; i++) begin
      v(1,0,0,0, 1,0,0,2,0,  2,1,0,0,(i-1 > 3) ? 3 : i-1);
      v(1,0,0,0, 1,0,0,2,0,  1,0,1,0,(i > 3) ? 3 : i);
    end
    v(1,0,0,0, 1,0,0,2,0,  2,1,0,0,3);
    // Direction flip: flag re-evaluated against T=1 while holding, then step down
    v(1,0,0,0, 0,1,0,2,0,  2,0,0,0,3);
    v(1,0,0,0, 1,1,0,2,0,  1,1,0,0,3);
    // Reset mid-operation with flag, done and tally all set
    v(1,0,1,3, 0,0,1,4,0,  3,0,0,0,3);
    v(1,0,0,0, 1,0,1,4,0,  4,1,0,0,3);
    v(1,0,0,0, 1,0,1,4,0,  4,1,0,1,3);
    v(0,0,1,2, 1,0,1,4,0,  0,0,0,0,0);
    // Reset glitches between edges are ignored
    v(1,0,1,2, 0,0,0,4,0,  2,0,0,0,0);
    v(1,0,0,0, 1,0,0,4,1,  3,0,0,0,0);
    v(1,0,0,0, 1,0,0,4,1,  4,1,0,0,0);
    v(1,0,0,0, 1,0,0,4,0,  1,0,1,0,1);

    foreach (vecs[k]) begin
      n_rst            = vecs[k].rst_n;
      bus.clear        = vecs[k].clr;
      bus.load         = vecs[k].ld;
      bus.load_val     = vecs[k].lv;
      bus.count_enable = vecs[k].en;
      bus.count_down   = vecs[k].dn;
      bus.one_shot     = vecs[k].os;
      bus.rollover_val = vecs[k].rv;
      if (vecs[k].glitch) begin
        #1 n_rst = 1'b0;
        #2 n_rst = 1'b1;
      end
      @(posedge clk);
      #1;
      n_vec++;
      check(k, "count_out",      int'(bus.count_out),      int'(vecs[k].e_cnt));
      check(k, "rollover_flag",  int'(bus.rollover_flag),  int'(vecs[k].e_flag));
      check(k, "rollover_pulse", int'(bus.rollover_pulse), int'(vecs[k].e_pulse));
      check(k, "done",           int'(bus.done),           int'(vecs[k].e_done));
      check(k, "wrap_count",     int'(bus.wrap_count),     int'(vecs[k].e_wrap));
      $display("vec %0d: rst_n=%0d clr=%0d ld=%0d lv=%0d en=%0d dn=%0d os=%0d R=%0d -> cnt=%0d flag=%0d pulse=%0d done=%0d wrap=%0d",
               k, vecs[k].rst_n, vecs[k].clr, vecs[k].ld, vecs[k].lv, vecs[k].en,
               vecs[k].dn, vecs[k].os, vecs[k].rv, bus.count_out, bus.rollover_flag,
               bus.rollover_pulse, bus.done, bus.wrap_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/flex_updown_counter.md
Name: flex_updown_counter

Overview:
Parametrised successor to the team's flex counter. Adds up/down direction, synchronous parallel load, wrap/one-shot modes, a single-cycle rollover pulse and a saturating wrap tally. Used by timer and protocol blocks that need programmable down-counts, for example bit timers and timeout watchdogs.

Parameters:
NUM_CNT_BITS, 4, width of count, rollover_val and load_val
NUM_WRAP_BITS, 4, width of the saturating wrap tally

Ports:
clk  in  1  system clock, all state updates on rising edge
n_rst  in  1  reset; synchronous, active-low (sampled on clk rising edge only)
clear  in  1  synchronous clear of count, flags and tally
load  in  1  synchronous parallel load of load_val
load_val  in  NUM_CNT_BITS  value to load
count_enable  in  1  advance the count one step
count_down  in  1  0 = count up, 1 = count down
one_shot  in  1  0 = wrap mode, 1 = stop at terminal
rollover_val  in  NUM_CNT_BITS  top of count range, 1..2^N-1
count_out  out  NUM_CNT_BITS  registered count
rollover_flag  out  1  registered; count_out equals terminal value
rollover_pulse  out  1  registered one-cycle pulse on each wrap
done  out  1  sticky one-shot completion
wrap_count  out  NUM_WRAP_BITS  saturating number of wraps since clear

Behaviour:
- Reset: all outputs are registered. Reset values: count_out=0, rollover_flag=0, rollover_pulse=0, done=0, wrap_count=0. Reset is sampled only at the clk edge and overrides every other input.
- Priority per cycle: n_rst low > clear > load > count_enable > hold.
- Valid range is 1..R, where R = rollover_val. Terminal T = R when counting up, T = 1 when counting down. Direction is sampled in the cycle it is used.
- Clear: next count_out=0, done=0, wrap_count=0, flags=0.
- Load: next count_out = min(load_val, R). done is cleared; rollover_pulse=0; wrap_count is held.
- Count up with count_enable=1:
  - count_out<R: +1.
  - count_out==R, wrap mode: next=1, wrap event.
  - count_out>R, which can only follow a rollover_val decrease: next=1, no wrap event.
- Count down with count_enable=1:
  - count_out>R: next=R, no wrap event.
  - count_out>1: -1.
  - count_out==1, wrap mode: next=R, wrap event.
  - count_out==0: next=R, no wrap event.
- One-shot mode: at terminal with count_enable=1, count holds and done is set. done stays set until clear, load or reset. No wrap event occurs in this mode.
- Wrap event: rollover_pulse=1 for exactly one cycle, registered with the new count. wrap_count increments and saturates at 2^NUM_WRAP_BITS-1.
- rollover_flag(next) = (count_next == T) using this cycle's direction, and is updated every cycle including hold. Latency: count, flag and pulse change 1 cycle after the enabling edge.
- rollover_val==0 is a degenerate case. count_out is forced to 0 next cycle whenever enable or load is asserted; all flags stay 0; done is never set.
- A mid-run direction change takes effect on the same cycle. The flag is recomputed against the new terminal.
- A mid-run change to rollover_val is handled by the out-of-range rules above. There is no x-propagation and no illegal state.
- Reset asserted mid-count: on the next edge all outputs return to reset values, regardless of clear, load or enable.

Decomposition:
- Package flex_counter_pkg holds:
  - typedef enum dir_t {DIR_UP, DIR_DOWN}
  - typedef enum mode_t {MODE_WRAP, MODE_ONESHOT}
  - a function that computes the terminal value from direction and R
- Natural sub-module: sat_counter (NUM_WRAP_BITS wide; inc, clear, saturate) for wrap_count. Everything else stays in one next-state always_comb plus one always_ff.

Test Plan:
1. Reset then up count: N=4, R=5, wrap mode, enable held 12 cycles.
   -> count_out 1,2,3,4,5,1,2,...
   -> rollover_flag high while count is 5.
   -> rollover_pulse high only on the cycle count goes 5->1.
   -> wrap_count reaches 2.
2. Down one-shot: load_val=9, R=9, count_down=1, one_shot=1, enable held 12 cycles.
   -> 9,8,...,1, then holds at 1.
   -> done set the cycle after enable is seen at 1.
   -> no pulse; wrap_count stays 0.
3. Priority on one edge: clear, load and enable asserted together, then load and enable together (load_val=3, R=5, count_out=4).
   -> first edge gives 0 with all flags 0.
   -> second edge gives 3 (enable ignored).
4. Range edges, wrap mode:
   - load_val=12 with R=7 -> loads 7.
   - With count_out=6, drop R to 4 then enable (up) -> 1, no pulse.
   - Down from count_out=0 -> R.
   - R=0 with enable -> 0, all flags 0.
5. Saturation and direction flip, NUM_WRAP_BITS=2, R=2, up, 10 wraps:
   -> wrap_count holds at 3.
   -> Flip count_down at count_out=2: rollover_flag drops next cycle (T becomes 1) and count becomes 1.
6. Reset mid-operation: at count_out=4, rollover_flag=1, done=1, pull n_rst low for one edge while enable=1.
   -> all outputs reset on that edge.
   -> Asynchronous n_rst glitches between edges have no effect.
